// File: rtl/screen_pkg.sv
// Shared screen and scheduler encodings for the LCD screen scheduler.
package screen_pkg;
  typedef enum logic [1:0] {
    CUBE   = 2'b00,
    COLOUR = 2'b01,
    CALIB  = 2'b10,
    BLANK  = 2'b11
  } screen_t;

  typedef enum logic [1:0] {
    BOOT    = 2'b00,
    RUN     = 2'b01,
    PENDING = 2'b10,
    SETTLE  = 2'b11
  } sched_state_t;

  localparam int SCR_DEFAULT_HOLDOFF = 200000;
endpackage

// File: rtl/screen_scheduler_holdoff_timer.sv
// Saturating down-counter that keeps touches blocked for a minimum time after a switch.
module holdoff_timer #(
  parameter int HOLDOFF_CYCLES = 200000
) (
  input  logic clk_1MHz,
  input  logic rst_n,
  input  logic load,
  output logic zero
);
  localparam int CW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_1MHz) begin
    if (!rst_n)              cnt_q <= '0;
    else if (load)           cnt_q <= CW'(HOLDOFF_CYCLES);
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/screen_scheduler.sv
// Chooses the screen feeding the LCD and gates touch events; switches land on frame boundaries.
module screen_scheduler
  import screen_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = SCR_DEFAULT_HOLDOFF,
  parameter bit CALIB_ON_RESET = 1'b1
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       frame_done,
  input  logic       touch_valid,
  input  logic       req_calib,
  input  logic       calib_done,
  input  logic       req_colour,
  input  logic       colour_done,
  output logic [1:0] screen_sel,
  output logic       cube_active,
  output logic       colour_active,
  output logic       calib_active,
  output logic       touch_cube,
  output logic       touch_colour,
  output logic       touch_calib,
  output logic       busy
);
  sched_state_t state_q, state_d;
  screen_t      scr_q, scr_d, target_q, target_d;
  logic         req_calib_q, calib_rise;
  logic         latch_q, latch_d;   // calibration request seen while settling
  logic         seen_q, seen_d;     // frame_done seen while settling
  logic         load, hold_zero;

  assign calib_rise = req_calib & ~req_calib_q;

  holdoff_timer #(.HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_holdoff (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .load     (load),
    .zero     (hold_zero)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    scr_d    = scr_q;
    latch_d  = latch_q;
    seen_d   = seen_q;
    load     = 1'b0;
    case (state_q)
      BOOT: begin
        target_d = CALIB_ON_RESET ? CALIB : CUBE;
        latch_d  = 1'b0;
        seen_d   = 1'b0;
        state_d  = PENDING;
      end
      RUN: begin
        if (calib_rise && scr_q != CALIB) begin
          target_d = CALIB;
          state_d  = PENDING;
        end else if (calib_done && scr_q == CALIB) begin
          target_d = CUBE;
          state_d  = PENDING;
        end else if (colour_done && scr_q == COLOUR) begin
          target_d = CUBE;
          state_d  = PENDING;
        end else if (req_colour && scr_q == CUBE) begin
          target_d = COLOUR;
          state_d  = PENDING;
        end
      end
      PENDING: begin
        if (calib_rise) target_d = CALIB;
        if (frame_done) begin
          scr_d   = calib_rise ? CALIB : target_q;
          load    = 1'b1;
          seen_d  = 1'b0;
          latch_d = 1'b0;
          state_d = SETTLE;
        end
      end
      default: begin // SETTLE
        if (frame_done) seen_d = 1'b1;
        if (calib_rise) latch_d = 1'b1;
        if ((seen_q || frame_done) && hold_zero) begin
          seen_d  = 1'b0;
          latch_d = 1'b0;
          if ((latch_q || calib_rise) && scr_q != CALIB) begin
            target_d = CALIB;
            state_d  = PENDING;
          end else begin
            state_d  = RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_1MHz) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      target_q      <= CUBE;
      scr_q         <= BLANK;
      latch_q       <= 1'b0;
      seen_q        <= 1'b0;
      req_calib_q   <= 1'b0;
      cube_active   <= 1'b0;
      colour_active <= 1'b0;
      calib_active  <= 1'b0;
      touch_cube    <= 1'b0;
      touch_colour  <= 1'b0;
      touch_calib   <= 1'b0;
      busy          <= 1'b1;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      scr_q         <= scr_d;
      latch_q       <= latch_d;
      seen_q        <= seen_d;
      req_calib_q   <= req_calib;
      cube_active   <= (scr_d == CUBE);
      colour_active <= (scr_d == COLOUR);
      calib_active  <= (scr_d == CALIB);
      // Routed by the screen live this cycle, even if a switch starts now.
      touch_cube    <= (state_q == RUN) && touch_valid && (scr_q == CUBE);
      touch_colour  <= (state_q == RUN) && touch_valid && (scr_q == COLOUR);
      touch_calib   <= (state_q == RUN) && touch_valid && (scr_q == CALIB);
      busy          <= (state_d != RUN);
    end
  end

  assign screen_sel = scr_q;
endmodule

// File: tb/tb_screen_scheduler.sv
// Directed bench for screen_scheduler with a scoreboard for routed touch pulses.
module tb_screen_scheduler;
  localparam int HOLD = 64;

  logic       clk_1MHz = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_done = 1'b0, touch_valid = 1'b0, req_calib = 1'b0;
  logic       calib_done = 1'b0, req_colour = 1'b0, colour_done = 1'b0;
  logic [1:0] screen_sel;
  logic       cube_active, colour_active, calib_active;
  logic       touch_cube, touch_colour, touch_calib, busy;

  int n_chk = 0;
  int n_pass = 0;
  logic [2:0] sb[$];   // expected {cube,colour,calib} touch pulses

  screen_scheduler #(.HOLDOFF_CYCLES(HOLD), .CALIB_ON_RESET(1'b1)) dut (
    .clk_1MHz(clk_1MHz), .rst_n(rst_n), .frame_done(frame_done),
    .touch_valid(touch_valid), .req_calib(req_calib), .calib_done(calib_done),
    .req_colour(req_colour), .colour_done(colour_done), .screen_sel(screen_sel),
    .cube_active(cube_active), .colour_active(colour_active),
    .calib_active(calib_active), .touch_cube(touch_cube),
    .touch_colour(touch_colour), .touch_calib(touch_calib), .busy(busy)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_1MHz);
    #1;
  endtask

  task automatic pulse_fd();
    frame_done = 1'b1; tick(); frame_done = 1'b0;
  endtask

  task automatic touch();
    touch_valid = 1'b1; tick(); touch_valid = 1'b0;
  endtask

  task automatic settle();
    pulse_fd();
    tick(HOLD + 6);
  endtask

  // {sel, cube, colour, calib, busy}
  function automatic logic [5:0] outs();
    return {screen_sel, cube_active, colour_active, calib_active, busy};
  endfunction

  always @(negedge clk_1MHz) begin
    if (rst_n && {touch_cube, touch_colour, touch_calib} != 3'b000) begin
      if (sb.size() == 0) chk("touch_unexpected", {touch_cube, touch_colour, touch_calib}, 3'b000);
      else chk("touch_route", {touch_cube, touch_colour, touch_calib}, sb.pop_front());
    end
  end

  initial begin
    tick(2);
    chk("reset_outs", outs(), {2'b11, 3'b000, 1'b1});
    rst_n = 1'b1;
    tick(8);
    chk("boot_pending", outs(), {2'b11, 3'b000, 1'b1});
    pulse_fd();
    chk("first_calib", outs(), {2'b10, 3'b001, 1'b1});
    touch();                               // dropped while settling
    tick(HOLD + 6);
    chk("settle_needs_frame", busy, 1'b1);
    pulse_fd();
    chk("settle_exit", outs(), {2'b10, 3'b001, 1'b0});

    sb.push_back(3'b001); touch(); tick();
    pulse_fd();                            // no effect in RUN
    chk("run_frame_noop", outs(), {2'b10, 3'b001, 1'b0});

    calib_done = 1'b1; tick(); calib_done = 1'b0;
    chk("calib_done_pend", outs(), {2'b10, 3'b001, 1'b1});
    pulse_fd();
    chk("to_cube", outs(), {2'b00, 3'b100, 1'b1});
    tick(5); pulse_fd(); tick(29);
    chk("holdoff_blocks", busy, 1'b1);
    tick(40);
    chk("holdoff_exit", busy, 1'b0);

    sb.push_back(3'b100); touch(); tick();
    req_colour = 1'b1; tick(); req_colour = 1'b0;
    tick(49);
    chk("colour_wait", outs(), {2'b00, 3'b100, 1'b1});
    pulse_fd();
    chk("to_colour", outs(), {2'b01, 3'b010, 1'b1});
    settle();
    chk("colour_run", busy, 1'b0);
    touch_valid = 1'b1; tick(); touch_valid = 1'b0;
    sb.push_back(3'b010);
    chk("touch_colour_hi", touch_colour, 1'b1);
    tick();
    chk("touch_colour_lo", touch_colour, 1'b0);

    // touch coincident with switch request goes to the old screen
    sb.push_back(3'b010);
    touch_valid = 1'b1; colour_done = 1'b1; tick();
    touch_valid = 1'b0; colour_done = 1'b0;
    chk("coincident_busy", busy, 1'b1);
    pulse_fd();
    chk("back_cube", outs(), {2'b00, 3'b100, 1'b1});
    settle();

    req_colour = 1'b1; tick(); req_colour = 1'b0;
    req_calib = 1'b1; tick(3);
    pulse_fd(); req_calib = 1'b0;
    chk("pend_override", outs(), {2'b10, 3'b001, 1'b1});
    settle();
    chk("calib_run", busy, 1'b0);

    calib_done = 1'b1; tick(); calib_done = 1'b0;
    pulse_fd(); settle();
    req_colour = 1'b1; tick(); req_colour = 1'b0;
    pulse_fd();
    chk("settle_colour", outs(), {2'b01, 3'b010, 1'b1});
    req_calib = 1'b1; tick(); req_calib = 1'b0;
    touch();
    pulse_fd(); tick(HOLD + 6);
    touch();
    chk("latched_calib", outs(), {2'b01, 3'b010, 1'b1});
    pulse_fd();
    chk("latched_to_calib", outs(), {2'b10, 3'b001, 1'b1});
    settle();

    calib_done = 1'b1; tick(); calib_done = 1'b0;
    pulse_fd(); settle();
    req_colour = 1'b1; tick(); req_colour = 1'b0;
    tick(3);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("reset_mid_switch", outs(), {2'b11, 3'b000, 1'b1});
    tick(2);
    pulse_fd();
    chk("reset_discard", outs(), {2'b10, 3'b001, 1'b1});
    tick(2);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/screen_scheduler.md
# screen_scheduler

Sequences which screen drives the LCD pixel stream and which screen receives touch events: cube-state view, colour-choice view or touch calibration. It sits between the touch controller, the three screen generators and the pixel multiplexer feeding the LCD SPI controller. It replaces the ad-hoc top-level screen state machine. Screen changes take effect only on frame boundaries. Touches are blocked while a new screen is being drawn, so one press cannot act on two screens.

## Interface
Parameters:
- HOLDOFF_CYCLES, 200000, minimum touch-blocking period after a switch (200 ms at 1 MHz).
- CALIB_ON_RESET, 1, first screen after reset: 1 = calibration, 0 = cube.

Ports:
- clk_1MHz  in  1  sole clock.
- rst_n  in  1  reset; synchronous, active-low.
- frame_done  in  1  one-cycle pulse; last pixel of a frame was sent (already in clk_1MHz domain).
- touch_valid  in  1  one-cycle pulse; new touch coordinates ready.
- req_calib  in  1  level; rising edge requests calibration.
- calib_done  in  1  pulse from the calibration screen.
- req_colour  in  1  pulse from the cube-state touch logic.
- colour_done  in  1  pulse from the colour-choice screen.
- screen_sel  out  2  pixel-mux select, screen_t encoding.
- cube_active, colour_active, calib_active  out  1 each  one-hot enables (all 0 when BLANK).
- touch_cube, touch_colour, touch_calib  out  1 each  gated touch pulses.
- busy  out  1  switch pending or settling.

## Operation
- screen_t: CUBE=2'b00, COLOUR=2'b01, CALIB=2'b10, BLANK=2'b11.
- States: BOOT, RUN, PENDING, SETTLE.
- Reset: state BOOT, screen_sel=BLANK, all active/touch outputs 0, busy=1, holdoff counter 0, edge register for req_calib cleared to 0.
- BOOT: target = CALIB_ON_RESET ? CALIB : CUBE. Goes to PENDING immediately.
- RUN: busy=0. Target selection, highest priority first:
  - req_calib rising edge (ignored if already CALIB) -> CALIB.
  - calib_done in CALIB -> CUBE.
  - colour_done in COLOUR -> CUBE.
  - req_colour in CUBE -> COLOUR.
  - Any other request is ignored.
  - A valid target moves the FSM to PENDING.
- PENDING: busy=1; touches dropped. A req_calib rising edge overrides the stored target with CALIB; other requests are ignored. On frame_done: screen_sel <= target, load holdoff counter, go to SETTLE.
- SETTLE: touches dropped. Exit to RUN when both hold:
  - one further frame_done has been seen, and
  - the holdoff counter has reached 0.
  A req_calib rising edge seen in SETTLE is latched. On exit it goes straight to PENDING(CALIB), unless the current screen is already CALIB.
- Touch routing in RUN only: touch_<screen>=1 for one cycle for the active screen. Exactly one touch output pulses per accepted touch_valid.
- A frame_done in RUN has no effect.

## Timing
- frame_done at cycle t in PENDING -> screen_sel and active outputs change at t+1; busy stays 1.
- Touch routing latency: 1 cycle (registered).
- Holdoff counter width is $clog2(HOLDOFF_CYCLES+1). It is loaded at t+1 and decrements to 0 with saturation.
- SETTLE exit at the cycle both conditions hold -> busy=0 and state RUN at the next cycle.
- touch_valid coincident with the RUN->PENDING transition: routed to the old screen; the request wins the same cycle.
- frame_done coincident with a request in RUN: the request goes to PENDING and waits for the next frame_done. Same-cycle switching is not allowed.
- rst_n low mid-switch: returns to BOOT next cycle; pending/latched requests are discarded.

## Structure
- screen_pkg: screen_t enum, sched_state_t enum, SCR_DEFAULT_HOLDOFF constant.
- One sub-module, holdoff_timer: load/decrement/zero flag, parameterised by HOLDOFF_CYCLES.
- req_calib edge detector and all outputs are registered in screen_scheduler.

## Test plan
- Reset with CALIB_ON_RESET=1, frame_done at cycle 10 -> screen_sel=CALIB and calib_active=1 at cycle 11; busy=0 only after a second frame_done and 200000 cycles.
- In RUN on CUBE, req_colour pulse, then frame_done 50 cycles later -> screen_sel=COLOUR one cycle after frame_done; no screen_sel change before it.
- touch_valid during SETTLE -> no touch_* pulse. touch_valid in RUN on COLOUR -> touch_colour=1 for exactly one cycle, one cycle later.
- In PENDING(COLOUR), req_calib rises -> next frame_done selects CALIB; calib_done in RUN -> PENDING(CUBE) -> CUBE.
- req_calib rises during SETTLE of COLOUR -> after settle, PENDING(CALIB) with no RUN touches accepted in between.
- rst_n low during PENDING(COLOUR) -> screen_sel=BLANK and busy=1 next cycle; the old target is never applied.
